// File: rtl/alu_muldiv.sv
// MIPS execute unit: single-cycle ALU ops plus iterative shift-add multiply and restoring divide.
// Define ALU_MULDIV_SIGNED_EN to add signed MULT/DIV (ops 10/11) through a FIXUP state.
module alu_muldiv #(
   parameter int N = 32
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [3:0]   op,
   input  logic [N-1:0] inA,
   input  logic [N-1:0] inB,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] result,
   output logic [N-1:0] result_hi,
   output logic         zero,
   output logic         err
);
`ifdef ALU_MULDIV_SIGNED_EN
   typedef enum logic [2:0] {IDLE, MUL, DIV, FIXUP, DONE} state_t;
`else
   typedef enum logic [2:0] {IDLE, MUL, DIV, DONE} state_t;
`endif
   localparam int CW = $clog2(N);

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [N-1:0]   hi_q, hi_d, lo_q, lo_d, b_q, b_d;
   logic           div0_q, div0_d;
   logic [N-1:0]   res_q, res_d, res_hi_q, res_hi_d;
   logic           zero_q, zero_d, err_q, err_d;
`ifdef ALU_MULDIV_SIGNED_EN
   logic           sgn_q, sgn_d, neg_q, neg_d, neg_rem_q, neg_rem_d, is_div_q, is_div_d;
   logic [N-1:0]   mag_a, mag_b;
   logic [2*N-1:0] prod_fix;
`endif
   logic           load;
   logic [N-1:0]   alu_res;
   logic           alu_err, iter_mul, iter_div, iter_sgn;
   logic [N:0]     sum, trial;
   logic [2*N-1:0] prod_n;
   logic [N-1:0]   rem_n, quo_n;

   // Multiply keeps {hi,lo} as {partial sum, remaining multiplier}; divide as {remainder, dividend/quotient}.
   assign sum    = {1'b0, hi_q} + {1'b0, (lo_q[0] ? b_q : {N{1'b0}})};
   assign prod_n = {sum, lo_q[N-1:1]};
   assign trial  = {hi_q, lo_q[N-1]} - {1'b0, b_q};
   assign rem_n  = trial[N] ? {hi_q[N-2:0], lo_q[N-1]} : trial[N-1:0];
   assign quo_n  = {lo_q[N-2:0], ~trial[N]};
`ifdef ALU_MULDIV_SIGNED_EN
   assign mag_a    = inA[N-1] ? -inA : inA;
   assign mag_b    = inB[N-1] ? -inB : inB;
   assign prod_fix = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
`endif

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign result    = res_q;
   assign result_hi = res_hi_q;
   assign zero      = zero_q;
   assign err       = err_q;

   always_comb begin
      alu_res  = '0;
      alu_err  = 1'b0;
      iter_mul = 1'b0;
      iter_div = 1'b0;
      iter_sgn = 1'b0;
      case (op)
         4'd0:  alu_res = inA & inB;
         4'd1:  alu_res = inA | inB;
         4'd2:  alu_res = inA + inB;
         4'd6:  alu_res = inA - inB;
         4'd7:  alu_res = {{(N-1){1'b0}}, ($signed(inA) < $signed(inB))};
         4'd12: alu_res = ~(inA | inB);
         4'd8:  iter_mul = 1'b1;
         4'd9:  iter_div = 1'b1;
`ifdef ALU_MULDIV_SIGNED_EN
         4'd10: begin iter_mul = 1'b1; iter_sgn = 1'b1; end
         4'd11: begin iter_div = 1'b1; iter_sgn = 1'b1; end
`endif
         default: alu_err = 1'b1;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      b_d      = b_q;
      div0_d   = div0_q;
      res_d    = res_q;
      res_hi_d = res_hi_q;
      zero_d   = zero_q;
      err_d    = err_q;
      load     = 1'b0;
`ifdef ALU_MULDIV_SIGNED_EN
      sgn_d     = sgn_q;
      neg_d     = neg_q;
      neg_rem_d = neg_rem_q;
      is_div_d  = is_div_q;
`endif
      case (state_q)
         IDLE: if (in_valid) begin
            cnt_d  = CW'(N-1);
            hi_d   = '0;
            div0_d = 1'b0;
            if (iter_mul) begin
               state_d = MUL;
               lo_d    = inB;
               b_d     = inA;
            end else if (iter_div) begin
               state_d = DIV;
               lo_d    = inA;
               b_d     = inB;
               div0_d  = (inB == '0);
            end else begin
               state_d  = DONE;
               load     = 1'b1;
               res_d    = alu_res;
               res_hi_d = '0;
               err_d    = alu_err;
            end
`ifdef ALU_MULDIV_SIGNED_EN
            sgn_d     = iter_sgn;
            neg_d     = inA[N-1] ^ inB[N-1];
            neg_rem_d = inA[N-1];
            is_div_d  = iter_div;
            if (iter_sgn) begin
               lo_d = iter_mul ? mag_b : mag_a;
               b_d  = iter_mul ? mag_a : mag_b;
            end
`endif
         end
         MUL: begin
            hi_d  = prod_n[2*N-1:N];
            lo_d  = prod_n[N-1:0];
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) begin
`ifdef ALU_MULDIV_SIGNED_EN
               if (sgn_q) state_d = FIXUP; else
`endif
               begin
                  state_d  = DONE;
                  load     = 1'b1;
                  res_d    = prod_n[N-1:0];
                  res_hi_d = prod_n[2*N-1:N];
                  err_d    = 1'b0;
               end
            end
         end
         DIV: begin
            hi_d  = rem_n;
            lo_d  = quo_n;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) begin
`ifdef ALU_MULDIV_SIGNED_EN
               if (sgn_q) state_d = FIXUP; else
`endif
               begin
                  state_d  = DONE;
                  load     = 1'b1;
                  res_d    = quo_n;
                  res_hi_d = rem_n;
                  err_d    = div0_q;
               end
            end
         end
`ifdef ALU_MULDIV_SIGNED_EN
         // Divide-by-zero keeps the all-ones quotient; the remainder sign-restore then yields inA.
         FIXUP: begin
            state_d = DONE;
            load    = 1'b1;
            if (is_div_q) begin
               res_d    = (neg_q && !div0_q) ? -lo_q : lo_q;
               res_hi_d = neg_rem_q ? -hi_q : hi_q;
               err_d    = div0_q;
            end else begin
               res_d    = prod_fix[N-1:0];
               res_hi_d = prod_fix[2*N-1:N];
               err_d    = 1'b0;
            end
         end
`endif
         DONE: if (out_ready) begin
            state_d = IDLE;
            zero_d  = 1'b0;
            err_d   = 1'b0;
         end
         default: state_d = IDLE;
      endcase
      if (load) zero_d = (res_d == '0);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         b_q      <= '0;
         div0_q   <= 1'b0;
         res_q    <= '0;
         res_hi_q <= '0;
         zero_q   <= 1'b0;
         err_q    <= 1'b0;
`ifdef ALU_MULDIV_SIGNED_EN
         sgn_q     <= 1'b0;
         neg_q     <= 1'b0;
         neg_rem_q <= 1'b0;
         is_div_q  <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         b_q      <= b_d;
         div0_q   <= div0_d;
         res_q    <= res_d;
         res_hi_q <= res_hi_d;
         zero_q   <= zero_d;
         err_q    <= err_d;
`ifdef ALU_MULDIV_SIGNED_EN
         sgn_q     <= sgn_d;
         neg_q     <= neg_d;
         neg_rem_q <= neg_rem_d;
         is_div_q  <= is_div_d;
`endif
      end
   end
endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv: arithmetic reference model, per-cycle output monitor, directed vectors.
module tb_alu_muldiv;
   localparam int N = 32;

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b1;
   logic [3:0]   op = 4'd0;
   logic [N-1:0] inA = '0;
   logic [N-1:0] inB = '0;
   logic         in_ready, out_valid, zero, err;
   logic [N-1:0] result, result_hi;

   alu_muldiv #(.N(N)) dut (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .inA(inA), .inB(inB), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .result_hi(result_hi), .zero(zero), .err(err)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int n_chk = 0;
   int n_fail = 0;

   typedef struct {
      logic [N-1:0] res;
      logic [N-1:0] hi;
      logic         err;
      int           lat;
      int           acc;
      bit           lit;
      logic [N-1:0] lres;
      logic [N-1:0] lhi;
      logic         lerr;
      string        name;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   bit   seen = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference results straight from the operation definitions.
   function automatic exp_t model(input logic [3:0] o, input logic [N-1:0] a, input logic [N-1:0] b);
      exp_t e;
      logic [2*N-1:0] p;
      logic signed [2*N-1:0] sa, sb;
      logic signed [N-1:0] na, nb;
      e.res = '0; e.hi = '0; e.err = 1'b0; e.lat = 1;
      e.acc = 0; e.lit = 1'b0; e.lres = '0; e.lhi = '0; e.lerr = 1'b0; e.name = "";
      na = a; nb = b;
      case (o)
         4'd0:  e.res = a & b;
         4'd1:  e.res = a | b;
         4'd2:  e.res = a + b;
         4'd6:  e.res = a - b;
         4'd7:  e.res = (na < nb) ? 1 : 0;
         4'd12: e.res = ~(a | b);
         4'd8: begin
            p = {{N{1'b0}}, a} * {{N{1'b0}}, b};
            e.res = p[N-1:0]; e.hi = p[2*N-1:N]; e.lat = N + 1;
         end
         4'd9: begin
            e.lat = N + 1;
            if (b == 0) begin e.res = '1; e.hi = a; e.err = 1'b1; end
            else begin e.res = a / b; e.hi = a % b; end
         end
`ifdef ALU_MULDIV_SIGNED_EN
         4'd10: begin
            sa = na; sb = nb;
            p = sa * sb;
            e.res = p[N-1:0]; e.hi = p[2*N-1:N]; e.lat = N + 2;
         end
         4'd11: begin
            e.lat = N + 2;
            if (b == 0) begin e.res = '1; e.hi = a; e.err = 1'b1; end
            else begin e.res = na / nb; e.hi = na % nb; end
         end
`endif
         default: e.err = 1'b1;
      endcase
      return e;
   endfunction

   always @(negedge clock) begin
      if (!reset) begin
         if (out_valid) begin
            if (q.size() == 0) begin
               chk("spurious_valid", out_valid, 1'b0);
            end else begin
               mon_e = q[0];
               chk({mon_e.name, "_result"}, result, mon_e.res);
               chk({mon_e.name, "_result_hi"}, result_hi, mon_e.hi);
               chk({mon_e.name, "_err"}, err, mon_e.err);
               chk({mon_e.name, "_zero"}, zero, (mon_e.res == '0));
               chk({mon_e.name, "_in_ready_busy"}, in_ready, 1'b0);
               if (mon_e.lit) begin
                  chk({mon_e.name, "_lit_result"}, result, mon_e.lres);
                  chk({mon_e.name, "_lit_result_hi"}, result_hi, mon_e.lhi);
                  chk({mon_e.name, "_lit_err"}, err, mon_e.lerr);
               end
               if (!seen) begin
                  chk({mon_e.name, "_latency"}, cyc - mon_e.acc + 1, mon_e.lat);
                  seen = 1'b1;
               end
               if (out_ready) begin
                  $display("txn %s: result=%h result_hi=%h zero=%b err=%b", mon_e.name, result, result_hi, zero, err);
                  void'(q.pop_front());
                  seen = 1'b0;
               end
            end
         end else begin
            chk("zero_when_idle", zero, 1'b0);
         end
      end
   end

   task automatic issue(input logic [3:0] o, input logic [N-1:0] a, input logic [N-1:0] b,
                        input string nm, input bit lit = 1'b0, input logic [N-1:0] lr = '0,
                        input logic [N-1:0] lh = '0, input logic le = 1'b0);
      exp_t e;
      int w = 0;
      while (!in_ready && w < 200) begin
         @(posedge clock); #1;
         w++;
      end
      if (!in_ready) chk({nm, "_accept_timeout"}, in_ready, 1'b1);
      e = model(o, a, b);
      e.name = nm; e.lit = lit; e.lres = lr; e.lhi = lh; e.lerr = le;
      op = o; inA = a; inB = b; in_valid = 1'b1;
      @(posedge clock); #1;
      in_valid = 1'b0;
      e.acc = cyc;
      q.push_back(e);
      inA = $urandom; inB = $urandom; op = 4'($urandom_range(0, 15));
   endtask

   task automatic drain();
      int w = 0;
      while (q.size() != 0 && w < 100) begin
         @(posedge clock); #1;
         w++;
      end
      if (q.size() != 0) begin
         chk("drain_timeout", q.size(), 0);
         q.delete();
         seen = 1'b0;
      end
   endtask

   initial begin
      in_valid = 1'b1; op = 4'd2; inA = 32'd1; inB = 32'd1;
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b0; in_valid = 1'b0;
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_result", result, 0);
      chk("rst_result_hi", result_hi, 0);
      chk("rst_zero", zero, 1'b0);
      chk("rst_err", err, 1'b0);

      issue(4'd2, 32'd7, 32'd5, "add", 1'b1, 32'd12, 32'd0, 1'b0);
      issue(4'd6, 32'd5, 32'd5, "sub_zero", 1'b1, 32'd0, 32'd0, 1'b0);
      issue(4'd7, 32'hFFFFFFFF, 32'd1, "slt_neg", 1'b1, 32'd1, 32'd0, 1'b0);
      issue(4'd7, 32'd5, 32'hFFFFFFFF, "slt_pos");
      issue(4'd0, 32'hF0F0_1234, 32'h0FF0_FF00, "and");
      issue(4'd1, 32'hF000_0001, 32'h000F_0010, "or");
      issue(4'd12, 32'h0000_FFFF, 32'h00FF_0000, "nor", 1'b1, 32'hFF00_0000, 32'd0, 1'b0);
      issue(4'd2, 32'hFFFF_FFFF, 32'd2, "add_wrap", 1'b1, 32'd1, 32'd0, 1'b0);
      issue(4'd8, 32'hFFFFFFFF, 32'd2, "multu", 1'b1, 32'hFFFFFFFE, 32'h00000001, 1'b0);
      issue(4'd8, 32'h1234_5678, 32'h9ABC_DEF0, "multu_big");
      issue(4'd9, 32'd100, 32'd7, "divu", 1'b1, 32'd14, 32'd2, 1'b0);
      issue(4'd9, 32'd5, 32'd0, "divu_zero", 1'b1, 32'hFFFFFFFF, 32'd5, 1'b1);
      issue(4'd9, 32'hFFFF_FFFF, 32'h0001_0000, "divu_big");
      issue(4'd9, 32'd3, 32'd9, "divu_small");
      drain();

      // Backpressure: result must hold while out_ready stays low.
      out_ready = 1'b0;
      issue(4'd9, 32'd1000, 32'd9, "bp_divu", 1'b1, 32'd111, 32'd1, 1'b0);
      begin
         int w = 0;
         while (!out_valid && w < 100) begin
            @(posedge clock); #1;
            w++;
         end
      end
      chk("bp_valid_seen", out_valid, 1'b1);
      repeat (5) begin
         @(posedge clock); #1;
         chk("bp_in_ready_low", in_ready, 1'b0);
         chk("bp_valid_hold", out_valid, 1'b1);
      end
      out_ready = 1'b1;
      @(posedge clock); #1;
      chk("bp_release_in_ready", in_ready, 1'b1);
      chk("bp_release_valid", out_valid, 1'b0);

      issue(4'd15, 32'd9, 32'd3, "unknown_op", 1'b1, 32'd0, 32'd0, 1'b1);
      drain();

      // Reset mid-multiply aborts the operation.
      issue(4'd8, 32'hDEAD_BEEF, 32'h1111_1111, "multu_abort");
      repeat (9) @(posedge clock);
      #1;
      reset = 1'b1;
      q.delete();
      seen = 1'b0;
      @(posedge clock); #1;
      reset = 1'b0;
      chk("abort_out_valid", out_valid, 1'b0);
      chk("abort_in_ready", in_ready, 1'b1);
      chk("abort_result", result, 0);
      chk("abort_result_hi", result_hi, 0);
      issue(4'd8, 32'd3, 32'd4, "multu_after_rst", 1'b1, 32'd12, 32'd0, 1'b0);
      drain();

`ifdef ALU_MULDIV_SIGNED_EN
      issue(4'd10, 32'hFFFFFFFD, 32'd4, "mult", 1'b1, 32'hFFFFFFF4, 32'hFFFFFFFF, 1'b0);
      issue(4'd11, 32'hFFFFFFF9, 32'd2, "div", 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
      issue(4'd11, 32'd7, 32'hFFFFFFFE, "div_negb", 1'b1, 32'hFFFFFFFD, 32'd1, 1'b0);
      issue(4'd11, 32'hFFFFFFF7, 32'd0, "div_zero", 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF7, 1'b1);
      issue(4'd10, 32'hFFFFFFFB, 32'hFFFFFFFA, "mult_negneg", 1'b1, 32'd30, 32'd0, 1'b0);
`else
      issue(4'd10, 32'd3, 32'd4, "op10_unknown", 1'b1, 32'd0, 32'd0, 1'b1);
      issue(4'd11, 32'd8, 32'd2, "op11_unknown", 1'b1, 32'd0, 32'd0, 1'b1);
`endif
      drain();
      repeat (2) @(posedge clock);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
      $fatal(1, "watchdog");
   end
endmodule
